// File: rtl/ss_hit_store.sv
`default_nettype none
// ss_hit_store -- appends incoming hits to per-SSID lists, counts them, and reads a list back in order.
// Revision: 1.0
module ss_hit_store #(
  parameter int SSIDBITS  = 8,
  parameter int NROWS_HCM = 256,
  parameter int NCOLS_HLM = 16,
  parameter int MAXHITS   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 newAddress,
  input  logic [SSIDBITS-1:0]  SSID,
  input  logic [NCOLS_HLM-1:0] hitInfo,
  output logic                 storageReady,
  input  logic                 readRequest,
  input  logic [SSIDBITS-1:0]  readSSID,
  output logic                 readValid,
  output logic [NCOLS_HLM-1:0] readHit,
  output logic                 readDone,
  output logic                 hitDropped
);

  localparam int SLOTBITS = $clog2(MAXHITS);
  localparam int CNTBITS  = SLOTBITS + 1;
  localparam logic [SSIDBITS-1:0] LAST_ROW = SSIDBITS'(NROWS_HCM - 1);
  localparam logic [CNTBITS-1:0]  FULL_CNT = CNTBITS'(MAXHITS);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WRITE, S_READ} state_t;

  state_t state, state_nxt;

  logic [CNTBITS-1:0]   hcm [NROWS_HCM];
  logic [NCOLS_HLM-1:0] hlm [NROWS_HCM * MAXHITS];

  logic [SSIDBITS-1:0]  clr_ptr;
  logic [SSIDBITS-1:0]  wr_ssid;
  logic [NCOLS_HLM-1:0] wr_hit;
  logic [SSIDBITS-1:0]  rd_ssid;
  logic [CNTBITS-1:0]   rd_cnt;
  logic [CNTBITS-1:0]   rd_ptr;

  logic                 wr_ok;
  logic [CNTBITS-1:0]   wr_cnt;
  logic [CNTBITS-1:0]   rd_cnt_in;
  logic                 rd_accept;
  logic                 rd_emit;
  logic [SSIDBITS-1:0]  em_ssid;
  logic [CNTBITS-1:0]   em_ptr;
  logic [CNTBITS-1:0]   em_cnt;
  logic                 em_valid;
  logic [SSIDBITS+SLOTBITS-1:0] em_addr;

  assign storageReady = (state == S_IDLE);

  // Drop decision is made at accept time so hitDropped is visible during the WRITE cycle.
  assign wr_ok     = (int'(SSID) < NROWS_HCM) && (hcm[SSID] != FULL_CNT);
  assign wr_cnt    = hcm[wr_ssid];
  assign rd_cnt_in = (int'(readSSID) < NROWS_HCM) ? hcm[readSSID] : '0;
  assign rd_accept = (state == S_IDLE) && !newAddress && readRequest;
  assign rd_emit   = rd_accept || ((state == S_READ) && !readDone);

  // The accept cycle already produces the first output word, so readout has no dead cycle.
  assign em_ssid  = rd_accept ? readSSID  : rd_ssid;
  assign em_ptr   = rd_accept ? '0        : rd_ptr;
  assign em_cnt   = rd_accept ? rd_cnt_in : rd_cnt;
  assign em_valid = (em_ptr < em_cnt);
  assign em_addr  = {em_ssid, em_ptr[SLOTBITS-1:0]};

  always_ff @(posedge clock) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_ptr == LAST_ROW) state_nxt = S_IDLE;
      S_IDLE: begin
        if (newAddress)       state_nxt = S_WRITE;
        else if (readRequest) state_nxt = S_READ;
      end
      S_WRITE: state_nxt = S_IDLE;
      S_READ:  if (readDone) state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clr_ptr    <= '0;
      wr_ssid    <= '0;
      wr_hit     <= '0;
      rd_ssid    <= '0;
      rd_cnt     <= '0;
      rd_ptr     <= '0;
      readValid  <= 1'b0;
      readHit    <= '0;
      readDone   <= 1'b0;
      hitDropped <= 1'b0;
    end else begin
      readValid  <= 1'b0;
      readDone   <= 1'b0;
      hitDropped <= 1'b0;
      case (state)
        S_CLEAR: clr_ptr <= clr_ptr + 1'b1;
        S_IDLE: begin
          if (newAddress) begin
            wr_ssid    <= SSID;
            wr_hit     <= hitInfo;
            hitDropped <= !wr_ok;
          end else if (readRequest) begin
            rd_ssid <= readSSID;
            rd_cnt  <= rd_cnt_in;
          end
        end
        default: ;
      endcase
      if (rd_emit) begin
        if (em_valid) begin
          readValid <= 1'b1;
          readHit   <= hlm[em_addr];
          rd_ptr    <= em_ptr + 1'b1;
        end else begin
          readDone <= 1'b1;
        end
      end
    end
  end

  // Memories carry no reset; HCM is zeroed by the CLEAR sweep and HLM is only read below the count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == S_CLEAR) hcm[clr_ptr] <= '0;
      if ((state == S_WRITE) && !hitDropped) begin
        hcm[wr_ssid]                          <= wr_cnt + 1'b1;
        hlm[{wr_ssid, wr_cnt[SLOTBITS-1:0]}] <= wr_hit;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ss_hit_store.sv
`default_nettype none
// tb_ss_hit_store -- table, directed and random checks of ss_hit_store against per-SSID hit lists.
// Revision: 1.0
`timescale 1ns/1ps
module tb_ss_hit_store;

  localparam int NROWS   = 256;
  localparam int MAXHITS = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        newAddress = 1'b0;
  logic        readRequest = 1'b0;
  logic [7:0]  SSID = '0;
  logic [7:0]  readSSID = '0;
  logic [15:0] hitInfo = '0;
  logic        storageReady, readValid, readDone, hitDropped;
  logic [15:0] readHit;

  ss_hit_store #(.SSIDBITS(8), .NROWS_HCM(NROWS), .NCOLS_HLM(16), .MAXHITS(MAXHITS)) dut (
    .clock(clock), .reset(reset), .newAddress(newAddress), .SSID(SSID), .hitInfo(hitInfo),
    .storageReady(storageReady), .readRequest(readRequest), .readSSID(readSSID),
    .readValid(readValid), .readHit(readHit), .readDone(readDone), .hitDropped(hitDropped)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  // Reference: each SSID owns an ordered list of at most MAXHITS hits.
  logic [15:0] mhits [NROWS][MAXHITS];
  int          mcnt  [NROWS];

  typedef struct {
    logic [7:0]  ssid;
    logic [15:0] hit;
    logic        drop;
  } wvec_t;
  wvec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NROWS; i++) mcnt[i] = 0;
  endtask

  // Enter at a negedge; asserts reset across one posedge and times the CLEAR sweep.
  task automatic do_reset();
    int n;
    reset = 1'b1; newAddress = 1'b0; readRequest = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    check("rst_valid", readValid, 0);
    check("rst_done", readDone, 0);
    check("rst_drop", hitDropped, 0);
    check("rst_hit", readHit, 0);
    n = 0;
    while (!storageReady && n < 1000) begin
      n++;
      @(negedge clock);
    end
    check("clear_cycles", n, NROWS);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!storageReady && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (!storageReady) check("ready_timeout", storageReady, 1);
  endtask

  task automatic do_write(input logic [7:0] s, input logic [15:0] h, input logic exp_drop);
    wait_ready();
    newAddress = 1'b1; SSID = s; hitInfo = h;
    @(negedge clock);
    newAddress = 1'b0;
    check("wr_busy", storageReady, 0);
    check("wr_drop", hitDropped, exp_drop);
    if (!exp_drop && mcnt[s] < MAXHITS) begin
      mhits[s][mcnt[s]] = h;
      mcnt[s]++;
    end
    @(negedge clock);
  endtask

  task automatic do_read(input logic [7:0] s);
    wait_ready();
    readRequest = 1'b1; readSSID = s;
    @(negedge clock);
    readRequest = 1'b0;
    for (int p = 0; p < mcnt[s]; p++) begin
      check("rd_valid", readValid, 1);
      check("rd_hit", readHit, mhits[s][p]);
      check("rd_done_early", readDone, 0);
      @(negedge clock);
    end
    check("rd_valid_end", readValid, 0);
    check("rd_done", readDone, 1);
    check("rd_busy", storageReady, 0);
    if (mcnt[s] > 0) check("rd_hold", readHit, mhits[s][mcnt[s]-1]);
    @(negedge clock);
    check("rd_done_pulse", readDone, 0);
    check("rd_idle", storageReady, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", nerr);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h37, 16'h1111, 1'b0};
    tbl[1] = '{8'h37, 16'h2222, 1'b0};
    tbl[2] = '{8'h37, 16'h3737, 1'b0};
    for (int i = 0; i < 9; i++) tbl[3+i] = '{8'h84, 16'(16'h8400 + i), (i == 8)};

    // Reset sweep and empty readout
    do_reset();
    do_read(8'h37);

    // Table-driven writes: list order and overflow drop
    for (int i = 0; i < 12; i++) do_write(tbl[i].ssid, tbl[i].hit, tbl[i].drop);
    do_read(8'h37);
    do_read(8'h84);

    // Simultaneous write and read request: write wins, read follows
    wait_ready();
    newAddress = 1'b1; readRequest = 1'b1; SSID = 8'h10; readSSID = 8'h10; hitInfo = 16'hABCD;
    @(negedge clock);
    newAddress = 1'b0;
    check("both_write_first", storageReady, 0);
    check("both_nodrop", hitDropped, 0);
    check("both_no_read", readValid, 0);
    @(negedge clock);
    check("both_ready", storageReady, 1);
    @(negedge clock);
    readRequest = 1'b0;
    check("both_rd_valid", readValid, 1);
    check("both_rd_hit", readHit, 16'hABCD);
    @(negedge clock);
    check("both_rd_done", readDone, 1);
    @(negedge clock);

    // newAddress held for six cycles
    wait_ready();
    newAddress = 1'b1; SSID = 8'h05;
    for (int i = 0; i < 6; i++) begin
      hitInfo = 16'(16'h5000 + i);
      check("hold_ready", storageReady, (i % 2 == 0));
      if (storageReady && mcnt[5] < MAXHITS) begin
        mhits[5][mcnt[5]] = hitInfo;
        mcnt[5]++;
      end
      @(negedge clock);
    end
    newAddress = 1'b0;
    do_read(8'h05);

    // Random mix of writes and reads over a few rows so lists fill and overflow
    for (int k = 0; k < 150; k++) begin
      logic [7:0] s;
      s = 8'(8'h40 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) do_write(s, 16'($urandom), (mcnt[s] >= MAXHITS));
      else                          do_read(s);
    end

    // Reset in the middle of a four-hit readout
    for (int i = 0; i < 4; i++) do_write(8'h66, 16'(16'h6600 + i), 1'b0);
    wait_ready();
    readRequest = 1'b1; readSSID = 8'h66;
    @(negedge clock);
    readRequest = 1'b0;
    check("abort_v0", readValid, 1);
    check("abort_h0", readHit, 16'h6600);
    @(negedge clock);
    check("abort_v1", readValid, 1);
    check("abort_h1", readHit, 16'h6601);
    do_reset();
    check("abort_busy_after", readDone, 0);
    do_read(8'h66);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
